// File: rtl/divb_seq_pkg.sv
// Shared definitions for the sequential magnitude divider: width derivations
// and the controller state encoding.
package divb_seq_pkg;

    function automatic int calc_qw(input int datawidth);
        return datawidth - 1;
    endfunction

    function automatic int calc_dw(input int coefwidth);
        return coefwidth - 1;
    endfunction

    function automatic int calc_nw(input int datawidth, input int coefwidth);
        return datawidth + coefwidth - 2;
    endfunction

    function automatic int calc_cw(input int qw);
        return (qw > 1) ? $clog2(qw) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FLAG
    } state_t;

endpackage

// File: rtl/divb_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor, and emit the quotient bit.
module divb_step #(
    parameter int DW = 7
) (
    input  logic [DW-1:0] p_i,
    input  logic          s_msb_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] p_o,
    output logic          qbit_o
);

    logic [DW:0] t;

    always_comb begin
        t      = {p_i, s_msb_i};
        qbit_o = (t >= {1'b0, d_i});
        // The partial remainder is always below d, so it fits in DW bits
        p_o    = DW'(qbit_o ? (t - {1'b0, d_i}) : t);
    end

endmodule

// File: rtl/divb_seq.sv
// Sequential unsigned magnitude divider, one quotient bit per clock, with
// start/busy/done handshake and saturating overflow / divide-by-zero flags.
module divb_seq
    import divb_seq_pkg::*;
#(
    parameter  int DATAWIDTH = 8,
    parameter  int COEFWIDTH = 8,
    localparam int QW        = calc_qw(DATAWIDTH),
    localparam int DW        = calc_dw(COEFWIDTH),
    localparam int NW        = calc_nw(DATAWIDTH, COEFWIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [DW-1:0] d,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] q,
    output logic [DW-1:0] rem,
    output logic          ovf,
    output logic          dz
);

    localparam int CW = calc_cw(QW);

    state_t        state_q;
    logic [DW-1:0] p_q;
    logic [QW-1:0] s_q;
    logic [QW-1:0] quot_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] d_q;
    logic          busy_q, done_q, ovf_q, dz_q;
    logic [QW-1:0] q_q;
    logic [DW-1:0] rem_q;

    logic [DW-1:0] p_d;
    logic          qbit;
    logic [QW-1:0] quot_d;
    logic [DW-1:0] n_hi;

    assign n_hi   = n[NW-1:QW];
    assign quot_d = QW'({quot_q, qbit});

    divb_step #(.DW(DW)) u_step (
        .p_i     (p_q),
        .s_msb_i (s_q[QW-1]),
        .d_i     (d_q),
        .p_o     (p_d),
        .qbit_o  (qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            s_q     <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        d_q    <= d;
                        p_q    <= n_hi;
                        s_q    <= n[QW-1:0];
                        quot_q <= '0;
                        cnt_q  <= CW'(QW - 1);
                        busy_q <= 1'b1;
                        ovf_q  <= 1'b0;
                        dz_q   <= 1'b0;
                        if (d == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= FLAG;
                        end else if (n_hi >= d) begin
                            ovf_q   <= 1'b1;
                            state_q <= FLAG;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_q    <= p_d;
                    s_q    <= s_q << 1;
                    quot_q <= quot_d;
                    if (cnt_q == '0) begin
                        q_q     <= quot_d;
                        rem_q   <= p_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FLAG: begin
                    q_q     <= '1;
                    rem_q   <= '0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_divb_seq.sv
// Self-checking bench for divb_seq: latency-based behavioural model compared
// every cycle, directed literal cases, and randomized operand streams.
module tb_divb_seq;

    localparam int QW = 7;
    localparam int DW = 7;
    localparam int NW = 14;
    localparam int QMAX = (1 << QW) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] n     = '0;
    logic [DW-1:0] d     = '0;
    logic          busy, done, ovf, dz;
    logic [QW-1:0] q;
    logic [DW-1:0] rem;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    divb_seq #(.DATAWIDTH(8), .COEFWIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .n     (n),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .rem   (rem),
        .ovf   (ovf),
        .dz    (dz)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: an accepted start schedules a result a fixed number
    // of edges later; results come from plain integer division.
    int m_left = 0;
    bit m_busy = 0, m_done = 0, m_ovf = 0, m_dz = 0;
    int m_q = 0, m_rem = 0;
    int p_q = 0, p_rem = 0;
    bit p_ovf = 0, p_dz = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0; m_busy <= 0; m_done <= 0;
            m_q <= 0; m_rem <= 0; m_ovf <= 0; m_dz <= 0;
        end else begin
            m_done <= 0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1; m_busy <= 0;
                    m_q <= p_q; m_rem <= p_rem; m_ovf <= p_ovf; m_dz <= p_dz;
                end
            end else if (start) begin
                m_busy <= 1;
                if (int'(d) == 0) begin
                    p_q <= QMAX; p_rem <= 0; p_ovf <= 0; p_dz <= 1; m_left <= 1;
                end else if (int'(n) / int'(d) > QMAX) begin
                    p_q <= QMAX; p_rem <= 0; p_ovf <= 1; p_dz <= 0; m_left <= 1;
                end else begin
                    p_q <= int'(n) / int'(d); p_rem <= int'(n) % int'(d);
                    p_ovf <= 0; p_dz <= 0; m_left <= QW;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("q", q, m_q);
            chk("rem", rem, m_rem);
            if (m_done) begin
                chk("ovf", ovf, m_ovf);
                chk("dz", dz, m_dz);
            end
        end
    end

    task automatic issue(input int nv, input int dv);
        @(posedge clk); #1;
        n = NW'(nv); d = DW'(dv); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat = 0 means done seen in the first negedge after the call
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done) return;
            lat++;
        end
        chk({name, " timeout"}, done, 1);
    endtask

    task automatic dir_op(input string name, input int nv, input int dv,
                          input int eq, input int erem, input int eovf,
                          input int edz, input int elat);
        int lat;
        issue(nv, dv);
        wait_done(name, lat);
        chk({name, " latency"}, lat, elat);
        chk({name, " q"}, q, eq);
        chk({name, " rem"}, rem, erem);
        chk({name, " ovf"}, ovf, eovf);
        chk({name, " dz"}, dz, edz);
    endtask

    initial begin
        int lat, a, b, r, na, nb, nr;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset q", q, 0);
        chk("reset rem", rem, 0);
        chk("reset ovf", ovf, 0);
        chk("reset dz", dz, 0);
        reset = 1'b0;
        chk_en = 1'b1;

        dir_op("exact", 5000, 50, 100, 0, 0, 0, 7);
        dir_op("withrem", 5037, 50, 100, 37, 0, 0, 7);
        dir_op("maxlegal", 16255, 127, 127, 126, 0, 0, 7);
        dir_op("divzero", 1234, 0, 127, 0, 0, 1, 1);
        dir_op("overflow", 8000, 50, 127, 0, 1, 0, 1);
        dir_op("dzprio", 16383, 0, 127, 0, 0, 1, 1);
        dir_op("justfits", 6399, 50, 127, 49, 0, 0, 7);
        dir_op("justovf", 6400, 50, 127, 0, 1, 0, 1);
        dir_op("zero", 0, 1, 0, 0, 0, 0, 7);

        // start while busy is ignored; start in the done cycle is accepted
        issue(5000, 50);
        @(posedge clk); #1;
        n = NW'(999); d = DW'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored", lat);
        chk("ignored q", q, 100);
        chk("ignored rem", rem, 0);
        n = NW'(5037); d = DW'(50); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("b2b", lat);
        chk("b2b latency", lat, 7);
        chk("b2b q", q, 100);
        chk("b2b rem", rem, 37);

        // reset in the middle of a division
        issue(12345, 100);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort q", q, 0);
        chk("abort rem", rem, 0);
        chk("abort ovf", ovf, 0);
        chk("abort dz", dz, 0);
        @(negedge clk);
        chk("abort no done", done, 0);
        #2 reset = 1'b0;
        dir_op("after reset", 12345, 100, 123, 45, 0, 0, 7);

        // start held high: operands refreshed in each done cycle
        a = $urandom_range(1, 127); b = $urandom_range(0, 127); r = $urandom_range(0, a - 1);
        @(posedge clk); #1;
        n = NW'(a * b + r); d = DW'(a); start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            wait_done("rnd", lat);
            chk("rnd q", q, b);
            chk("rnd rem", rem, r);
            chk("rnd ovf", ovf, 0);
            chk("rnd dz", dz, 0);
            if (i < 2999) begin
                na = $urandom_range(1, 127);
                nb = $urandom_range(0, 127);
                nr = $urandom_range(0, na - 1);
                n = NW'(na * nb + nr); d = DW'(na);
                a = na; b = nb; r = nr;
            end else begin
                start = 1'b0;
            end
        end

        // unconstrained operands, including zero divisors and overflow
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue($urandom_range(0, 16383),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127));
            wait_done("free", lat);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
